// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Framing: sync, 16-bit length, hi/lo data words, XOR checksum.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] csum_step(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Frames a UART byte stream into instruction memory writes and
// holds the CPU in reset until a checksummed image has landed.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         n_q, n_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                in_frame;
  logic                next_in_frame;
  logic                timeout_hit;
  logic [15:0]         n_full;
  logic [ADDR_W:0]     idx_inc;

  always_comb begin
    in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
               (state_q == S_CSUM);
    // A byte in the expiry cycle wins over the timeout
    timeout_hit = (TIMEOUT != 0) && in_frame && !rx_valid &&
                  (cnt_q == TO_LAST);
    n_full  = {len_hi_q, rx_data};
    idx_inc = idx_q + (ADDR_W + 1)'(1);

    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    hi_d     = hi_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            idx_d   = '0;
            xor_d   = '0;
          end
        end
        S_LEN_HI: begin
          len_hi_d = rx_data;
          xor_d    = csum_step(xor_q, rx_data);
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          n_d   = n_full;
          xor_d = csum_step(xor_q, rx_data);
          if (n_full == 16'd0)
            state_d = S_CSUM;
          else if ({1'b0, n_full} > DEPTH)
            state_d = S_ERR;
          else
            state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = rx_data;
          xor_d   = csum_step(xor_q, rx_data);
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          idx_d   = idx_inc;
          xor_d   = csum_step(xor_q, rx_data);
          if (16'(idx_inc) == n_q)
            state_d = S_CSUM;
          else
            state_d = S_DATA_HI;
        end
        S_CSUM: begin
          state_d = (rx_data == xor_q) ? S_RUN : S_ERR;
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      state_d = S_ERR;
    end

    next_in_frame = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                    (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                    (state_d == S_CSUM);
    if ((TIMEOUT == 0) || rx_valid || !next_in_frame)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);

    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_hi_q  <= '0;
      n_q       <= '0;
      hi_q      <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      n_q       <= n_d;
      hi_q      <= hi_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, length limits,
// inter-byte timeout, reload from RUN and mid-frame reset.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int AW = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];

  logic [7:0] fa[9] = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34,
                        8'h56, 8'h78, 8'h9A, 8'hBC};

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_we"},      32'(imem_we), 32'd0);
    check({tag, "_addr"},    32'(imem_addr), 32'd0);
    check({tag, "_wdata"},   32'(imem_wdata), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
    check({tag, "_err"},     32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0] acc;

    repeat (3) @(negedge clk);
    check_reset_vals("in_rst");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    acc = 8'h00;
    for (int i = 1; i < 9; i++) acc = csum_step(acc, fa[i]);
    check("pkg_csum", 32'(acc), 32'h2D);

    // good 3-word frame
    for (int i = 0; i < 9; i++) send(fa[i]);
    check("a_pre_done", 32'(done), 32'd0);
    check("a_pre_cpurst", 32'(cpu_rst), 32'd1);
    send(8'h2D);
    check("a_done", 32'(done), 32'd1);
    check("a_cpurst", 32'(cpu_rst), 32'd0);
    check("a_err", 32'(err), 32'd0);
    check("a_nwr", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      check("a_addr0", 32'(wa[0]), 32'd0);
      check("a_data0", 32'(wd[0]), 32'h1234);
      check("a_addr1", 32'(wa[1]), 32'd1);
      check("a_data1", 32'(wd[1]), 32'h5678);
      check("a_addr2", 32'(wa[2]), 32'd2);
      check("a_data2", 32'(wd[2]), 32'h9ABC);
    end
    idle(3);
    check("hold_addr", 32'(imem_addr), 32'd2);
    check("hold_wdata", 32'(imem_wdata), 32'h9ABC);
    check("hold_we", 32'(imem_we), 32'd0);

    // reload from RUN with a 1-word frame
    clear_log();
    send(8'hA5);
    check("rl_cpurst", 32'(cpu_rst), 32'd1);
    check("rl_done", 32'(done), 32'd0);
    send(8'h00);
    send(8'h01);
    send(8'hBE);
    send(8'hEF);
    check("rl_we_pulse", 32'(imem_we), 32'd1);
    send(8'h50);
    check("rl_we_low", 32'(imem_we), 32'd0);
    check("rl_done2", 32'(done), 32'd1);
    check("rl_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("rl_addr", 32'(wa[0]), 32'd0);
      check("rl_data", 32'(wd[0]), 32'hBEEF);
    end

    // bad checksum
    clear_log();
    for (int i = 0; i < 9; i++) send(fa[i]);
    send(8'h2C);
    check("bad_err", 32'(err), 32'd1);
    check("bad_cpurst", 32'(cpu_rst), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_nwr", 32'(wa.size()), 32'd3);

    // oversize length
    clear_log();
    send(8'hA5);
    check("ovr_err_clr", 32'(err), 32'd0);
    send(8'h00);
    send(8'h81);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_nwr", 32'(wa.size()), 32'd0);

    // maximum length accepted, then stalls out
    send(8'hA5);
    send(8'h00);
    send(8'h80);
    check("max_ok", 32'(err), 32'd0);
    idle(TO);
    check("max_to_err", 32'(err), 32'd1);

    // empty image
    clear_log();
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpurst", 32'(cpu_rst), 32'd0);
    check("empty_nwr", 32'(wa.size()), 32'd0);

    // stall just short of the timeout
    clear_log();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    idle(TO - 1);
    send(8'h34);
    check("to_short_err", 32'(err), 32'd0);
    check("to_short_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) check("to_short_data", 32'(wd[0]), 32'h1234);
    send(8'h27);
    check("to_short_done", 32'(done), 32'd1);

    // stall the full timeout
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    idle(TO - 1);
    check("to_pre_err", 32'(err), 32'd0);
    idle(1);
    check("to_err", 32'(err), 32'd1);
    check("to_cpurst", 32'(cpu_rst), 32'd1);
    check("to_done", 32'(done), 32'd0);

    // reset between the two bytes of word 1
    clear_log();
    send(8'hA5);
    send(8'h00);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    #2 rst = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'h44);
    send(8'h55);
    idle(2);
    check("noise_nwr", 32'(wa.size()), 32'd1);
    check("noise_done", 32'(done), 32'd0);
    check("noise_err", 32'(err), 32'd0);
    check("noise_cpurst", 32'(cpu_rst), 32'd1);
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hBE);
    send(8'hEF);
    send(8'h50);
    check("post_done", 32'(done), 32'd1);
    check("post_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) check("post_data", 32'(wd[1]), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
